// File: rtl/aesl_deadlock_pkg.sv
// Shared definitions for the deadlock timeout watchdog: FSM state encoding
// and the default blocked-cycle threshold.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WATCH    = 2'd1,
    ST_DEADLOCK = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/aesl_lsb_encoder.sv
// Lowest-set-bit encoder: reports the smallest index set in the mask,
// and whether any bit is set at all.
module aesl_lsb_encoder #(
  parameter int NUM_CH = 10,
  parameter int CH_W   = 4
) (
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   first_ch,
  output logic              first_vld
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    first_ch  = '0;
    first_vld = |mask;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) first_ch = CH_W'(i);
    end
  end

endmodule

// File: rtl/aesl_deadlock_timeout.sv
// Deadlock watchdog: counts consecutive blocked cycles reported by the monitor
// stage and latches a deadlock once TIMEOUT is reached, until cleared.
module aesl_deadlock_timeout
  import aesl_deadlock_pkg::*;
#(
  parameter int NUM_CH  = 10,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16,
  parameter int CH_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block_in,
  input  logic [NUM_CH-1:0] axis_block_sigs,
  input  logic              clear,
  output logic              deadlock,
  output logic [NUM_CH-1:0] blocked_mask,
  output logic [CNT_W-1:0]  blocked_cycles,
  output logic [CH_W-1:0]   first_ch,
  output logic              first_vld
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [NUM_CH-1:0] mask_n;

  // Next-state logic; the counter leaves WATCH on the edge it reaches
  // TIMEOUT, so it can never exceed the threshold or wrap.
  always_comb begin
    state_n = state;
    cnt_n   = blocked_cycles;
    mask_n  = blocked_mask;
    case (state)
      ST_IDLE: begin
        if (block_in) begin
          cnt_n   = ONE_CNT;
          mask_n  = axis_block_sigs;
          state_n = (TIMEOUT_CNT == ONE_CNT) ? ST_DEADLOCK : ST_WATCH;
        end else begin
          cnt_n  = '0;
          mask_n = '0;
        end
      end
      ST_WATCH: begin
        if (block_in) begin
          cnt_n  = blocked_cycles + ONE_CNT;
          mask_n = blocked_mask | axis_block_sigs;
          if (cnt_n == TIMEOUT_CNT) state_n = ST_DEADLOCK;
        end else begin
          cnt_n   = '0;
          mask_n  = '0;
          state_n = ST_IDLE;
        end
      end
      ST_DEADLOCK: begin
        if (clear) begin
          cnt_n   = '0;
          mask_n  = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        mask_n  = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // deadlock gets its own flop so the output is a pure register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      blocked_cycles <= '0;
      blocked_mask   <= '0;
      deadlock       <= 1'b0;
    end else begin
      state          <= state_n;
      blocked_cycles <= cnt_n;
      blocked_mask   <= mask_n;
      deadlock       <= (state_n == ST_DEADLOCK);
    end
  end

  aesl_lsb_encoder #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_lsb_encoder (
    .mask     (blocked_mask),
    .first_ch (first_ch),
    .first_vld(first_vld)
  );

endmodule

// File: tb/tb_aesl_deadlock_timeout.sv
// Bench for aesl_deadlock_timeout: a TIMEOUT=8 and a TIMEOUT=1 instance share
// stimulus and are checked every cycle against a run-length model.
module tb_aesl_deadlock_timeout;

  logic       clock = 1'b0;
  logic       reset;
  logic       block_in;
  logic [9:0] axis_block_sigs;
  logic       clear;

  logic       dl_a, dl_b;
  logic [9:0] mask_a, mask_b;
  logic [15:0] cyc_a, cyc_b;
  logic [3:0] ch_a, ch_b;
  logic       vld_a, vld_b;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  check_en = 1'b0;

  // model: per instance, run length of the blocked episode, accumulated mask, latch
  int       m_run  [2];
  logic [9:0] m_mask [2];
  bit       m_lat  [2];

  always #5 clock = ~clock;

  aesl_deadlock_timeout #(
    .NUM_CH(10), .TIMEOUT(8), .CNT_W(16), .CH_W(4)
  ) dut_a (
    .clock(clock), .reset(reset), .block_in(block_in),
    .axis_block_sigs(axis_block_sigs), .clear(clear),
    .deadlock(dl_a), .blocked_mask(mask_a), .blocked_cycles(cyc_a),
    .first_ch(ch_a), .first_vld(vld_a)
  );

  aesl_deadlock_timeout #(
    .NUM_CH(10), .TIMEOUT(1), .CNT_W(16), .CH_W(4)
  ) dut_b (
    .clock(clock), .reset(reset), .block_in(block_in),
    .axis_block_sigs(axis_block_sigs), .clear(clear),
    .deadlock(dl_b), .blocked_mask(mask_b), .blocked_cycles(cyc_b),
    .first_ch(ch_b), .first_vld(vld_b)
  );

  function automatic int timeoutOf(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  function automatic int lowestSet(input logic [9:0] m);
    int r;
    bit found;
    r = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!found && m[i]) begin
        r = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic b, input logic [9:0] s, input logic c, input logic r);
    block_in        = b;
    axis_block_sigs = s;
    clear           = c;
    reset           = r;
    @(negedge clock);
  endtask

  // A deadlock is declared once the blocked run reaches the threshold and
  // holds until acknowledged; an unblocked cycle discards the episode.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_run[k] = 0; m_mask[k] = '0; m_lat[k] = 1'b0;
      end else if (m_lat[k]) begin
        if (clear) begin
          m_run[k] = 0; m_mask[k] = '0; m_lat[k] = 1'b0;
        end
      end else if (!block_in) begin
        m_run[k] = 0; m_mask[k] = '0;
      end else begin
        m_run[k]  = m_run[k] + 1;
        m_mask[k] = m_mask[k] | axis_block_sigs;
        if (m_run[k] == timeoutOf(k)) m_lat[k] = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("a.deadlock", 32'(dl_a),   32'(m_lat[0]));
      checkOutput("a.mask",     32'(mask_a), 32'(m_mask[0]));
      checkOutput("a.cycles",   32'(cyc_a),  32'(m_run[0]));
      checkOutput("a.first_ch", 32'(ch_a),   32'(lowestSet(m_mask[0])));
      checkOutput("a.first_vld",32'(vld_a),  32'(m_mask[0] != '0));
      checkOutput("b.deadlock", 32'(dl_b),   32'(m_lat[1]));
      checkOutput("b.mask",     32'(mask_b), 32'(m_mask[1]));
      checkOutput("b.cycles",   32'(cyc_b),  32'(m_run[1]));
      checkOutput("b.first_ch", 32'(ch_b),   32'(lowestSet(m_mask[1])));
      checkOutput("b.first_vld",32'(vld_b),  32'(m_mask[1] != '0));
    end
  end

  initial begin
    applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b1);
    applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b1);
    check_en = 1'b1;
    checkOutput("rst.deadlock", 32'(dl_a), 32'd0);
    checkOutput("rst.cycles",   32'(cyc_a), 32'd0);
    checkOutput("rst.mask",     32'(mask_a), 32'd0);
    checkOutput("rst.first_ch", 32'(ch_a), 32'd0);
    checkOutput("rst.first_vld",32'(vld_a), 32'd0);

    // eight blocked cycles on channel 2 reach the threshold exactly
    repeat (7) applyStimulus(1'b1, 10'h004, 1'b0, 1'b0);
    checkOutput("lat7.deadlock", 32'(dl_a), 32'd0);
    checkOutput("lat7.cycles",   32'(cyc_a), 32'd7);
    applyStimulus(1'b1, 10'h004, 1'b0, 1'b0);
    checkOutput("lat8.deadlock", 32'(dl_a), 32'd1);
    checkOutput("lat8.cycles",   32'(cyc_a), 32'd8);
    checkOutput("lat8.mask",     32'(mask_a), 32'h004);
    checkOutput("lat8.first_ch", 32'(ch_a), 32'd2);
    checkOutput("t1.deadlock",   32'(dl_b), 32'd1);
    checkOutput("t1.cycles",     32'(cyc_b), 32'd1);

    // latched state ignores new sigs; clear with block_in high releases it
    repeat (2) applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
    checkOutput("frz.mask",   32'(mask_a), 32'h004);
    checkOutput("frz.cycles", 32'(cyc_a), 32'd8);
    applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b0);
    checkOutput("clr.deadlock", 32'(dl_a), 32'd0);
    checkOutput("clr.mask",     32'(mask_a), 32'd0);
    checkOutput("clr.cycles_b", 32'(cyc_b), 32'd0);
    checkOutput("clr.dl_b",     32'(dl_b), 32'd0);

    // seven blocked, one gap, seven blocked never deadlocks; clear in WATCH ignored
    repeat (6) applyStimulus(1'b1, 10'h004, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'h004, 1'b1, 1'b0);
    checkOutput("gap.pre_cycles", 32'(cyc_a), 32'd7);
    applyStimulus(1'b0, 10'h004, 1'b0, 1'b0);
    checkOutput("gap.cycles", 32'(cyc_a), 32'd0);
    checkOutput("gap.mask",   32'(mask_a), 32'd0);
    repeat (7) applyStimulus(1'b1, 10'h004, 1'b0, 1'b0);
    checkOutput("gap.deadlock", 32'(dl_a), 32'd0);
    checkOutput("gap.cycles2",  32'(cyc_a), 32'd7);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

    // mask accumulates across one episode
    applyStimulus(1'b1, 10'h100, 1'b0, 1'b0);
    checkOutput("acc.b_first_ch", 32'(ch_b), 32'd8);
    applyStimulus(1'b1, 10'h100, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 10'h002, 1'b0, 1'b0);
    checkOutput("acc.mask",     32'(mask_a), 32'h102);
    checkOutput("acc.first_ch", 32'(ch_a), 32'd1);
    checkOutput("acc.cycles",   32'(cyc_a), 32'd4);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

    // reset mid-WATCH restarts the full count
    repeat (5) applyStimulus(1'b1, 10'h001, 1'b0, 1'b0);
    checkOutput("rw.cycles5", 32'(cyc_a), 32'd5);
    applyStimulus(1'b1, 10'h001, 1'b0, 1'b1);
    checkOutput("rw.cycles", 32'(cyc_a), 32'd0);
    checkOutput("rw.mask",   32'(mask_a), 32'd0);
    checkOutput("rw.vld",    32'(vld_a), 32'd0);
    checkOutput("rw.dl_b",   32'(dl_b), 32'd0);
    repeat (7) applyStimulus(1'b1, 10'h001, 1'b0, 1'b0);
    checkOutput("rw.deadlock7", 32'(dl_a), 32'd0);
    applyStimulus(1'b1, 10'h001, 1'b0, 1'b0);
    checkOutput("rw.deadlock8", 32'(dl_a), 32'd1);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

    // TIMEOUT=1: one blocked cycle latches; clear wins over block_in
    applyStimulus(1'b1, 10'h020, 1'b0, 1'b0);
    checkOutput("t1b.deadlock", 32'(dl_b), 32'd1);
    checkOutput("t1b.cycles",   32'(cyc_b), 32'd1);
    checkOutput("t1b.first_ch", 32'(ch_b), 32'd5);
    applyStimulus(1'b1, 10'h020, 1'b1, 1'b0);
    checkOutput("t1c.deadlock", 32'(dl_b), 32'd0);
    checkOutput("t1c.cycles",   32'(cyc_b), 32'd0);
    checkOutput("t1c.mask",     32'(mask_b), 32'd0);
    checkOutput("t1c.a_cycles", 32'(cyc_a), 32'd2);

    repeat (2) applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
